// File: rtl/rtype_ctrl_pkg.sv
// Shared types and constants for the R-type control sequencer.
package rtype_ctrl_pkg;

    // Sequencer states; the encoding is visible on state_dbg.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        T6   = 3'd7
    } state_t;

    // Opcodes: ADD..XOR complete in one ALU cycle, MUL/DIV are multicycle.
    localparam int OP_ADD  = 3;
    localparam int OP_SUB  = 4;
    localparam int OP_SHR  = 5;
    localparam int OP_SHRA = 6;
    localparam int OP_SHL  = 7;
    localparam int OP_ROR  = 8;
    localparam int OP_ROL  = 9;
    localparam int OP_AND  = 10;
    localparam int OP_OR   = 11;
    localparam int OP_NEG  = 12;
    localparam int OP_NOT  = 13;
    localparam int OP_XOR  = 14;
    localparam int OP_MUL  = 15;
    localparam int OP_DIV  = 16;

    // IR layout: opcode at the top, then Ra, Rb, Rc packed downward.
    localparam int IR_OP_MSB = 31;

    function automatic logic op_is_single(input int op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic op_is_muldiv(input int op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic idx_out_of_range(input int idx, input int nregs);
        return idx >= nregs;
    endfunction

endpackage

// File: rtl/rtype_ctrl_seq_reg_sel_decode.sv
// Register index to one-hot select, with an out-of-range indication.
module reg_sel_decode #(
    parameter int NREGS = 16,
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [NREGS-1:0] onehot,
    output logic             out_of_range
);

    // Range flag is independent of en so it can be used for decode checks.
    always_comb begin
        out_of_range = (32'(idx) >= NREGS);
        onehot       = '0;
        if (en && !out_of_range) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rtype_ctrl_seq.sv
// Fetch/execute sequencer for register-register ALU instructions.
module rtype_ctrl_seq
    import rtype_ctrl_pkg::*;
#(
    parameter int NREGS       = 16,
    parameter int REG_IDX_W   = 4,
    parameter int OP_W        = 5,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    input  logic             alu_done,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin_low,
    output logic             Zin_high,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic [NREGS-1:0] Rout,
    output logic [NREGS-1:0] Rin,
    output logic [OP_W-1:0]  operation,
    output logic [2:0]       state_dbg
);

    localparam int RA_MSB = IR_OP_MSB - OP_W;
    localparam int RB_MSB = RA_MSB - REG_IDX_W;
    localparam int RC_MSB = RB_MSB - REG_IDX_W;
    localparam int CNT_W  = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

    state_t                 state;
    logic [CNT_W-1:0]       wait_cnt;
    logic [OP_W-1:0]        op_q;
    logic [REG_IDX_W-1:0]   ra_q;
    logic [REG_IDX_W-1:0]   rc_q;
    logic                   muldiv_q;

    logic [OP_W-1:0]        ir_op;
    logic [REG_IDX_W-1:0]   ir_ra;
    logic [REG_IDX_W-1:0]   ir_rb;
    logic [REG_IDX_W-1:0]   ir_rc;
    logic                   unused_ir_low;

    logic                   dec_muldiv;
    logic                   dec_illegal;
    logic                   alu_timeout;
    logic                   rout_oor;
    logic                   rin_oor;
    logic                   rout_en;
    logic                   rin_en;
    logic [REG_IDX_W-1:0]   rout_idx;
    logic [REG_IDX_W-1:0]   rin_idx;
    logic [NREGS-1:0]       rout_sel;
    logic [NREGS-1:0]       rin_sel;

    assign ir_op = ir[IR_OP_MSB -: OP_W];
    assign ir_ra = ir[RA_MSB -: REG_IDX_W];
    assign ir_rb = ir[RB_MSB -: REG_IDX_W];
    assign ir_rc = ir[RC_MSB -: REG_IDX_W];
    // Low IR bits hold immediates that R-type instructions never use.
    assign unused_ir_low = ^ir[RC_MSB-REG_IDX_W:0];

    // Rout selects Rb while decoding (T3) and Rc while executing (T4).
    assign rout_idx = (state == T3) ? ir_rb : rc_q;
    assign rout_en  = (state == T3) || (state == T4);
    // In T3 the Rin decoder is only used for its Ra range check.
    assign rin_idx  = (state == T3) ? ir_ra : ra_q;
    assign rin_en   = (state == T5) && !muldiv_q;

    reg_sel_decode #(
        .NREGS (NREGS),
        .IDX_W (REG_IDX_W)
    ) u_rout_dec (
        .idx          (rout_idx),
        .en           (rout_en),
        .onehot       (rout_sel),
        .out_of_range (rout_oor)
    );

    reg_sel_decode #(
        .NREGS (NREGS),
        .IDX_W (REG_IDX_W)
    ) u_rin_dec (
        .idx          (rin_idx),
        .en           (rin_en),
        .onehot       (rin_sel),
        .out_of_range (rin_oor)
    );

    // Instruction decode from the live IR; only meaningful in T3.
    always_comb begin
        dec_muldiv  = op_is_muldiv(32'(ir_op));
        dec_illegal = !(op_is_single(32'(ir_op)) || dec_muldiv)
                      || rout_oor || rin_oor
                      || idx_out_of_range(32'(ir_rc), NREGS);
        alu_timeout = muldiv_q && !alu_done && (wait_cnt == CNT_LAST);
    end

    // State register plus the instruction fields captured at decode.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            wait_cnt <= '0;
            op_q     <= '0;
            ra_q     <= '0;
            rc_q     <= '0;
            muldiv_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) state <= T0;
                T0:   state <= T1;
                T1:   if (mem_ready) state <= T2;
                T2:   state <= T3;
                T3: begin
                    op_q     <= ir_op;
                    ra_q     <= ir_ra;
                    rc_q     <= ir_rc;
                    muldiv_q <= dec_muldiv;
                    wait_cnt <= '0;
                    state    <= dec_illegal ? IDLE : T4;
                end
                T4: begin
                    if (!muldiv_q || alu_done) begin
                        state <= T5;
                    end else if (alu_timeout) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                T5: begin
                    if (muldiv_q) begin
                        state <= T6;
                    end else begin
                        state <= start ? T0 : IDLE;
                    end
                end
                T6:      state <= start ? T0 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobe decode of the current state (T1/T4 also qualify on handshakes).
    always_comb begin
        done      = 1'b0;
        illegal   = 1'b0;
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin_low   = 1'b0;
        Zin_high  = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        operation = '0;
        case (state)
            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin_low = 1'b1;
            end
            T1: begin
                Read    = 1'b1;
                MDRin   = 1'b1;
                // PC is loaded only on the ready cycle so a stall cannot double-increment.
                PCin    = mem_ready;
                Zlowout = mem_ready;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                illegal = dec_illegal;
                Yin     = !dec_illegal;
            end
            T4: begin
                operation = op_q;
                if (!muldiv_q) begin
                    Zin_low = 1'b1;
                end else if (alu_done) begin
                    Zin_low  = 1'b1;
                    Zin_high = 1'b1;
                end else begin
                    illegal = alu_timeout;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                LOin    = muldiv_q;
                done    = !muldiv_q;
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign Rout      = (state == T3 && dec_illegal) ? '0 : rout_sel;
    assign Rin       = rin_sel;
    assign state_dbg = state;

endmodule
